// File: rtl/alu_pkg.sv
// alu_pkg: types and defaults shared by the multicycle ALU and its slice.
//   alu_op_e    : cntrl encoding (001 and 111 are undefined and yield zero)
//   alu_state_e : sequencer states
//   SLICE_W_DEF / NUM_SLICES_DEF : default slice geometry (16 x 4 = 64 bits)
package alu_pkg;

    localparam int SLICE_W_DEF    = 16;
    localparam int NUM_SLICES_DEF = 4;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational datapath for one SLICE_W-bit slice of the ALU.
//   i_op        : cntrl code latched for the operation
//   i_a, i_b    : operand slices
//   i_carry     : carry into bit 0 of this slice
//   o_res       : slice result
//   o_carry     : carry out of the slice MSB
//   o_msb_carry : carry into the slice MSB (overflow = o_carry ^ o_msb_carry)
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [2:0]         i_op,
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_carry,
    output logic [SLICE_W-1:0] o_res,
    output logic               o_carry,
    output logic               o_msb_carry
);

    logic [SLICE_W-1:0] w_b_eff;
    logic [SLICE_W:0]   w_sum;

    always_comb begin
        // Subtraction is A + ~B + 1; the +1 enters as the slice-0 carry.
        w_b_eff     = (i_op == ALU_SUBTRACT) ? ~i_b : i_b;
        w_sum       = {1'b0, i_a} + {1'b0, w_b_eff} + {{SLICE_W{1'b0}}, i_carry};
        o_carry     = w_sum[SLICE_W];
        // Sum bit = a ^ b ^ cin, so cin of the MSB is recovered by XOR-ing back.
        o_msb_carry = w_sum[SLICE_W-1] ^ i_a[SLICE_W-1] ^ w_b_eff[SLICE_W-1];

        case (i_op)
            ALU_PASS_B:   o_res = i_b;
            ALU_ADD:      o_res = w_sum[SLICE_W-1:0];
            ALU_SUBTRACT: o_res = w_sum[SLICE_W-1:0];
            ALU_AND:      o_res = i_a & i_b;
            ALU_OR:       o_res = i_a | i_b;
            ALU_XOR:      o_res = i_a ^ i_b;
            default:      o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: 64-bit ALU that processes one SLICE_W slice per cycle.
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid / in_ready    : request handshake; transfer when both are 1 at a rising edge
//   A, B, cntrl, set_flags : operands, operation, flag-register update enable
//   out_valid / out_ready  : result handshake; result held while out_valid=1 and out_ready=0
//   result, negative, zero, overflow, carry_out : result and per-op flags
//   flag_n, flag_z, flag_v, flag_c              : registered NZVC flags
//   o_dbg_state            : current sequencer state (alu_state_e encoding)
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] A,
    input  logic [SLICE_W*NUM_SLICES-1:0] B,
    input  logic [2:0]                    cntrl,
    input  logic                          set_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] result,
    output logic                          negative,
    output logic                          zero,
    output logic                          overflow,
    output logic                          carry_out,
    output logic                          flag_n,
    output logic                          flag_z,
    output logic                          flag_v,
    output logic                          flag_c,
    output logic [1:0]                    o_dbg_state
);

    localparam int DATA_W = SLICE_W * NUM_SLICES;
    localparam int CNT_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    alu_state_e         r_state, w_next_state;
    logic [DATA_W-1:0]  r_a, r_b, r_result;
    logic [2:0]         r_op;
    logic               r_set_flags;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_neg, r_zero, r_ovf, r_cout;
    logic               r_fn, r_fz, r_fv, r_fc;

    logic [SLICE_W-1:0] w_a_slice, w_b_slice, w_res_slice;
    logic [DATA_W-1:0]  w_result_next;
    logic               w_carry, w_msb_carry, w_last, w_arith;

    // Operand slice select and result merge for the slice addressed by r_cnt.
    always_comb begin
        w_a_slice     = '0;
        w_b_slice     = '0;
        w_result_next = r_result;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_slice = r_a[k*SLICE_W +: SLICE_W];
                w_b_slice = r_b[k*SLICE_W +: SLICE_W];
                w_result_next[k*SLICE_W +: SLICE_W] = w_res_slice;
            end
        end
    end

    alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .i_op        (r_op),
        .i_a         (w_a_slice),
        .i_b         (w_b_slice),
        .i_carry     (r_carry),
        .o_res       (w_res_slice),
        .o_carry     (w_carry),
        .o_msb_carry (w_msb_carry)
    );

    assign w_last  = (r_cnt == CNT_W'(NUM_SLICES - 1));
    assign w_arith = (r_op == ALU_ADD) || (r_op == ALU_SUBTRACT);

    // Sequencer: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Sequencer: next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = EXEC;
            end
            EXEC: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch, slice counter, result and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_set_flags <= 1'b0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_neg       <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cout      <= 1'b0;
            r_fn        <= 1'b0;
            r_fz        <= 1'b0;
            r_fv        <= 1'b0;
            r_fc        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a         <= A;
                        r_b         <= B;
                        r_op        <= cntrl;
                        r_set_flags <= set_flags;
                        r_cnt       <= '0;
                        r_carry     <= (cntrl == ALU_SUBTRACT);
                    end
                end
                EXEC: begin
                    r_result <= w_result_next;
                    r_carry  <= w_carry;
                    r_cnt    <= r_cnt + 1'b1;
                    // Final slice: flags are derived from the fully merged result.
                    if (w_last) begin
                        r_neg  <= w_result_next[DATA_W-1];
                        r_zero <= ~|w_result_next;
                        r_ovf  <= w_arith & (w_carry ^ w_msb_carry);
                        r_cout <= w_arith & w_carry;
                        if (r_set_flags) begin
                            r_fn <= w_result_next[DATA_W-1];
                            r_fz <= ~|w_result_next;
                            r_fv <= w_arith & (w_carry ^ w_msb_carry);
                            r_fc <= w_arith & w_carry;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result      = r_result;
    assign negative    = r_neg;
    assign zero        = r_zero;
    assign overflow    = r_ovf;
    assign carry_out   = r_cout;
    assign flag_n      = r_fn;
    assign flag_z      = r_fz;
    assign flag_v      = r_fv;
    assign flag_c      = r_fc;
    assign o_dbg_state = r_state;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter SLICE_W, default 16, the adder/logic slice width processed per cycle.
REQ-002 SHALL have parameter NUM_SLICES, default 4, the slice count; SLICE_W*NUM_SLICES = 64.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request.
REQ-007 A, B  input  64 each  operands.
REQ-008 cntrl  input  3  000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
REQ-009 set_flags  input  1  update the flag register with this op's flags.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  64  operation result.
REQ-013 negative, zero, overflow, carry_out  output  1 each  per-op flags.
REQ-014 flag_n, flag_z, flag_v, flag_c  output  1 each  registered NZVC flags.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 IDLE: in_ready=1; when in_valid=1 at a rising edge, latch A, B, cntrl, set_flags, clear the slice counter, set carry = (cntrl==SUB), go to EXEC.
REQ-017 EXEC: each cycle computes slice k (bits SLICE_W*k+SLICE_W-1 : SLICE_W*k) into the result register, passing the slice carry-out to slice k+1; SUB uses A + ~B + 1.
REQ-018 After slice NUM_SLICES-1, go to DONE; out_valid rises exactly NUM_SLICES edges after the accepting edge (4 cycles by default).
REQ-019 DONE: out_valid=1; result and all flags held stable until out_ready=1 at a rising edge, then go to IDLE.
REQ-020 in_ready SHALL be 0 in EXEC and DONE; requests presented there are not accepted.
REQ-021 negative = result[63]; zero = (result == 0), for every op.
REQ-022 overflow = signed overflow of A+B or A-B; carry_out = carry out of bit 63; both 0 for non-arithmetic ops.
REQ-023 Undefined cntrl (001, 111): result 0, zero=1, other flags 0.
REQ-024 On entry to DONE with latched set_flags=1, the flag register loads {negative, zero, overflow, carry_out}; otherwise it holds.
REQ-025 Inputs A, B, cntrl, set_flags changing during EXEC/DONE SHALL NOT affect the result.

Reset
REQ-026 reset asserted, at any time including mid-EXEC, SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, all per-op flags 0, flag_n/z/v/c=0, and discard the in-flight op.
REQ-027 The first edge after reset deassertion SHALL be able to accept a request.

Structure
REQ-028 Shared package alu_pkg SHALL hold the cntrl encoding enum (ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR), the FSM state enum, and the SLICE_W/NUM_SLICES defaults.
REQ-029 One combinational sub-module alu_slice SHALL compute one SLICE_W slice (op select, carry in, carry out, bit-(SLICE_W-1) carry-in for overflow); the top holds FSM, counter, operand/result/flag registers.

Verification
REQ-030 ADD A=1, B=1 accepted at edge 0 -> out_valid at edge 4, result=2, N=0 Z=0 V=0 C=0.
REQ-031 ADD A=B=64'h7FFFFFFFFFFFFFFF, set_flags=1 -> result 64'hFFFFFFFFFFFFFFFE, N=1 V=1 C=0 Z=0; flag_n=1, flag_v=1 after DONE.
REQ-032 ADD A=64'h000000000000FFFF, B=1 -> result 64'h0000000000010000 (inter-slice carry); SUB A=B=1 -> result 0, Z=1, C=1, V=0.
REQ-033 Hold out_ready=0 for 3 cycles in DONE -> result/flags stable, in_ready=0, out_valid=1; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Assert reset during EXEC slice 2 -> out_valid=0, in_ready=1, all flags 0 immediately; following XOR A=B=64'h1010101010101010 with set_flags=1 -> result 0, Z=1, flag_z=1, flag_c=0.
